// File: rtl/switch_conditioner.sv
// Multi-channel switch conditioner: synchroniser, polarity fix, counter debouncer,
// rise/fall pulses, and a stretched reset request from one selected channel.
module switch_conditioner #(
  parameter int                  CHANNELS        = 10,
  parameter int                  SYNC_STAGES     = 3,
  parameter int                  DEBOUNCE_CYCLES = 16,
  parameter logic [CHANNELS-1:0] INVERT          = '0,
  parameter int                  RESET_CH        = 0,
  parameter int                  RESET_HOLD      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] sw_i,
  output logic [CHANNELS-1:0] sw_o,
  output logic [CHANNELS-1:0] sw_rise_o,
  output logic [CHANNELS-1:0] sw_fall_o,
  output logic                sw_changed_o,
  output logic                rst_req_o
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("switch_conditioner: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("switch_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("switch_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (RESET_CH < 0 || RESET_CH >= CHANNELS) begin : g_bad_reset_ch
    $error("switch_conditioner: RESET_CH must be in [0, CHANNELS)");
  end
  if (RESET_HOLD < 0) begin : g_bad_hold
    $error("switch_conditioner: RESET_HOLD must be >= 0");
  end

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_q  [CHANNELS];
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_d;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] done;
  logic [CHANNELS-1:0] sw_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;
  logic                req_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    done = '0;
    s    = sync_q[SYNC_STAGES-1] ^ INVERT;
    for (int n = 0; n < CHANNELS; n++) begin
      done[n] = (s[n] != sw_o[n]) && (cnt_q[n] == CNT_MAX);
    end
    sw_d   = sw_o ^ done;
    rise_d = done & s;
    fall_d = done & ~s;

    if (rise_d[RESET_CH])      hold_d = '0;
    else if (fall_d[RESET_CH]) hold_d = HOLD_LOAD;
    else if (hold_q != '0)     hold_d = hold_q - HOLD_W'(1);
    else                       hold_d = hold_q;

    // Registering the OR of next-state terms keeps rst_req_o a single flop output.
    req_d = sw_d[RESET_CH] | (hold_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the sync chain and counters are small flop arrays, not RAM, so they are reset explicitly.
      // Sync flops reset to the idle raw level so active-low channels read as released.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= INVERT;
      for (int n = 0; n < CHANNELS; n++) cnt_q[n] <= '0;
      sw_o      <= '0;
      sw_rise_o <= '0;
      sw_fall_o <= '0;
      hold_q    <= '0;
      rst_req_o <= 1'b0;
    end else begin
      sync_q[0] <= sw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      for (int n = 0; n < CHANNELS; n++) begin
        if (s[n] == sw_o[n] || done[n]) cnt_q[n] <= '0;
        else                            cnt_q[n] <= cnt_q[n] + CNT_W'(1);
      end
      sw_o      <= sw_d;
      sw_rise_o <= rise_d;
      sw_fall_o <= fall_d;
      hold_q    <= hold_d;
      rst_req_o <= req_d;
    end
  end

  assign sw_changed_o = |(sw_rise_o | sw_fall_o);

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner; channel 6 is built active-low, all else defaults.
module tb_switch_conditioner;

  localparam logic [9:0] INV  = 10'b00_0100_0000;
  localparam logic [9:0] BASE = 10'b00_0100_0000;  // idle levels: channel 6 released = raw high

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [9:0] sw_i  = BASE;
  logic [9:0] sw_o, sw_rise_o, sw_fall_o;
  logic       sw_changed_o, rst_req_o;

  int n_cmp = 0;
  int n_err = 0;

  switch_conditioner #(
    .CHANNELS(10), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(16),
    .INVERT(INV), .RESET_CH(0), .RESET_HOLD(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sw_i(sw_i), .sw_o(sw_o),
    .sw_rise_o(sw_rise_o), .sw_fall_o(sw_fall_o),
    .sw_changed_o(sw_changed_o), .rst_req_o(rst_req_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Holds reset for three edges with the given input levels; returns just after the
  // last reset edge, so the caller's next drive lands before edge 0.
  task automatic do_reset(input logic [9:0] lvl, input string tag);
    sw_i  = lvl;
    rst_i = 1'b1;
    repeat (3) step();
    check({tag, "_rst_outs"}, {sw_o, sw_rise_o, sw_fall_o, sw_changed_o, rst_req_o}, 32'h0);
    rst_i = 1'b0;
  endtask

  int rise_cnt, fall_cnt, rise_edge;

  initial begin
    // Reset state: outputs are zero one cycle after the first reset edge.
    step();
    check("reset_first_edge", {sw_o, sw_rise_o, sw_fall_o, sw_changed_o, rst_req_o}, 32'h0);

    // 1: single rise on channel 3, accepted at edge 18.
    do_reset(BASE, "t1");
    for (int e = 0; e <= 20; e++) begin
      sw_i[3] = 1'b1;
      step();
      check("t1_sw_o", sw_o, (e >= 18) ? 32'h008 : 32'h0);
      check("t1_rise", sw_rise_o, (e == 18) ? 32'h008 : 32'h0);
      check("t1_fall", sw_fall_o, 32'h0);
      check("t1_changed", sw_changed_o, (e == 18) ? 32'h1 : 32'h0);
    end

    // 2: a 10-cycle glitch on channel 5 never reaches the output.
    do_reset(BASE, "t2");
    for (int e = 0; e < 40; e++) begin
      sw_i[5] = (e < 10);
      step();
      check("t2_quiet", {sw_o, sw_rise_o, sw_fall_o, sw_changed_o}, 32'h0);
    end

    // 3: channel 2 chatters every 5 cycles, then settles high before edge 40.
    do_reset(BASE, "t3");
    rise_cnt = 0; fall_cnt = 0; rise_edge = -1;
    for (int e = 0; e <= 70; e++) begin
      sw_i[2] = (e >= 40) ? 1'b1 : (((e / 5) % 2) == 0);
      step();
      if (sw_rise_o[2]) begin rise_cnt++; rise_edge = e; end
      if (sw_fall_o[2]) fall_cnt++;
    end
    check("t3_rise_count", rise_cnt, 1);
    check("t3_rise_edge", rise_edge, 58);
    check("t3_fall_count", fall_cnt, 0);
    check("t3_final_sw_o", sw_o, 32'h004);

    // 4: reset channel held 100 cycles; request stretches 8 edges past the debounced fall.
    do_reset(BASE, "t4");
    for (int e = 0; e <= 130; e++) begin
      sw_i[0] = (e < 100);
      step();
      check("t4_rst_req", rst_req_o, (e >= 18 && e < 126) ? 32'h1 : 32'h0);
      if (e == 118) check("t4_fall_pulse", sw_fall_o, 32'h001);
    end

    // 5: simultaneous rise on channel 1 and fall on channel 4.
    do_reset(BASE, "t5");
    for (int e = 0; e < 20; e++) begin
      sw_i[4] = 1'b1;
      step();
    end
    check("t5_setup_sw_o", sw_o, 32'h010);
    for (int e = 0; e <= 20; e++) begin
      sw_i[1] = 1'b1;
      sw_i[4] = 1'b0;
      step();
      check("t5_pulses", {sw_rise_o, sw_fall_o}, (e == 18) ? {12'h0, 10'h002, 10'h010} : 32'h0);
      check("t5_changed", sw_changed_o, (e == 18) ? 32'h1 : 32'h0);
    end
    check("t5_final_sw_o", sw_o, 32'h002);

    // 6a: active-low channel 6 held pressed (raw 0) through reset release.
    do_reset(BASE & ~10'h040, "t6a");
    for (int e = 0; e <= 19; e++) begin
      step();
      check("t6a_sw_o", sw_o, (e >= 18) ? 32'h040 : 32'h0);
      check("t6a_rise", sw_rise_o, (e == 18) ? 32'h040 : 32'h0);
    end

    // 6b: reset pulsed when channel 7's count has reached 10 discards the progress.
    do_reset(BASE, "t6b");
    for (int e = 0; e <= 12; e++) begin
      sw_i[7] = 1'b1;
      step();
    end
    rst_i = 1'b1;
    step();
    check("t6b_rst_outs", {sw_o, sw_rise_o, sw_fall_o, sw_changed_o, rst_req_o}, 32'h0);
    rst_i = 1'b0;
    for (int e = 0; e <= 19; e++) begin
      step();
      check("t6b_sw_o", sw_o, (e >= 18) ? 32'h080 : 32'h0);
      check("t6b_rise", sw_rise_o, (e == 18) ? 32'h080 : 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
